// File: rtl/wb_arb_2m.sv
// Two-requester pipelined Wishbone arbiter sharing one master port.
// The grant is held for a whole CYC, and a watchdog aborts cycles the slave never answers.
module wb_arb_2m #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST_ASYNC_N,
  input  logic        EN,
  input  logic [31:0] WB_S0_ADR_IN,
  input  logic        WB_S0_CYC_IN,
  input  logic        WB_S0_STB_IN,
  input  logic        WB_S0_WE_IN,
  input  logic [3:0]  WB_S0_SEL_IN,
  input  logic [2:0]  WB_S0_CTI_IN,
  input  logic [1:0]  WB_S0_BTE_IN,
  input  logic [31:0] WB_S0_DAT_WR_IN,
  output logic        WB_S0_STALL_OUT,
  output logic        WB_S0_ACK_OUT,
  output logic        WB_S0_ERR_OUT,
  output logic [31:0] WB_S0_DAT_RD_OUT,
  input  logic [31:0] WB_S1_ADR_IN,
  input  logic        WB_S1_CYC_IN,
  input  logic        WB_S1_STB_IN,
  input  logic        WB_S1_WE_IN,
  input  logic [3:0]  WB_S1_SEL_IN,
  input  logic [2:0]  WB_S1_CTI_IN,
  input  logic [1:0]  WB_S1_BTE_IN,
  input  logic [31:0] WB_S1_DAT_WR_IN,
  output logic        WB_S1_STALL_OUT,
  output logic        WB_S1_ACK_OUT,
  output logic        WB_S1_ERR_OUT,
  output logic [31:0] WB_S1_DAT_RD_OUT,
  output logic [31:0] WB_M_ADR_OUT,
  output logic        WB_M_CYC_OUT,
  output logic        WB_M_STB_OUT,
  output logic        WB_M_WE_OUT,
  output logic [3:0]  WB_M_SEL_OUT,
  output logic [2:0]  WB_M_CTI_OUT,
  output logic [1:0]  WB_M_BTE_OUT,
  output logic [31:0] WB_M_DAT_WR_OUT,
  input  logic        WB_M_ACK_IN,
  input  logic        WB_M_STALL_IN,
  input  logic        WB_M_ERR_IN,
  input  logic [31:0] WB_M_DAT_RD_IN,
  output logic [1:0]  GNT_OUT,
  output logic        TIMEOUT_OUT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GNT0   = 3'd1,
    ST_GNT1   = 3'd2,
    ST_ABORT0 = 3'd3,
    ST_ABORT1 = 3'd4
  } state_t;

  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        abort_first_q, abort_first_d;

  logic [1:0]  cyc_in;
  logic [1:0]  grant_req;
  logic        own_idx;
  logic        slv_resp;
  logic [1:0]  gnt_vec;
  logic [1:0]  abort_vec;

  assign cyc_in    = {WB_S1_CYC_IN, WB_S0_CYC_IN};
  assign slv_resp  = WB_M_ACK_IN | WB_M_ERR_IN;
  assign own_idx   = (state_q == ST_GNT1) || (state_q == ST_ABORT1);
  assign gnt_vec   = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign abort_vec = {state_q == ST_ABORT1, state_q == ST_ABORT0};

  // State register
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      cnt_q         <= 16'd0;
      abort_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      abort_first_q <= abort_first_d;
    end
  end

  // Next-state logic; everything holds while EN is low
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    abort_first_d = abort_first_q;
    grant_req     = 2'b00;
    if (EN) begin
      abort_first_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (&cyc_in) begin
            grant_req = (PRIORITY_MODE != 0 || last_q) ? 2'b01 : 2'b10;
          end else begin
            grant_req = cyc_in;
          end
        end
        ST_GNT0, ST_GNT1: begin
          // Release has priority over the watchdog, and a response over the abort
          if (!cyc_in[own_idx]) begin
            if (cyc_in[!own_idx]) begin
              grant_req = own_idx ? 2'b01 : 2'b10;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (slv_resp) begin
            cnt_d = 16'd0;
          end else if (WDOG_EN && cnt_q == WDOG_LAST) begin
            state_d       = own_idx ? ST_ABORT1 : ST_ABORT0;
            abort_first_d = 1'b1;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_ABORT0, ST_ABORT1: begin
          if (!cyc_in[own_idx]) begin
            if (cyc_in[!own_idx]) begin
              grant_req = own_idx ? 2'b01 : 2'b10;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (grant_req[0]) begin
        state_d = ST_GNT0;
        last_d  = 1'b0;
        cnt_d   = 16'd0;
      end else if (grant_req[1]) begin
        state_d = ST_GNT1;
        last_d  = 1'b1;
        cnt_d   = 16'd0;
      end
    end
  end

  // Master-side mux driven from the registered grant
  always_comb begin
    WB_M_ADR_OUT    = 32'd0;
    WB_M_CYC_OUT    = 1'b0;
    WB_M_STB_OUT    = 1'b0;
    WB_M_WE_OUT     = 1'b0;
    WB_M_SEL_OUT    = 4'd0;
    WB_M_CTI_OUT    = 3'd0;
    WB_M_BTE_OUT    = 2'd0;
    WB_M_DAT_WR_OUT = 32'd0;
    if (gnt_vec[0]) begin
      WB_M_ADR_OUT    = WB_S0_ADR_IN;
      WB_M_CYC_OUT    = WB_S0_CYC_IN;
      WB_M_STB_OUT    = WB_S0_STB_IN;
      WB_M_WE_OUT     = WB_S0_WE_IN;
      WB_M_SEL_OUT    = WB_S0_SEL_IN;
      WB_M_CTI_OUT    = WB_S0_CTI_IN;
      WB_M_BTE_OUT    = WB_S0_BTE_IN;
      WB_M_DAT_WR_OUT = WB_S0_DAT_WR_IN;
    end else if (gnt_vec[1]) begin
      WB_M_ADR_OUT    = WB_S1_ADR_IN;
      WB_M_CYC_OUT    = WB_S1_CYC_IN;
      WB_M_STB_OUT    = WB_S1_STB_IN;
      WB_M_WE_OUT     = WB_S1_WE_IN;
      WB_M_SEL_OUT    = WB_S1_SEL_IN;
      WB_M_CTI_OUT    = WB_S1_CTI_IN;
      WB_M_BTE_OUT    = WB_S1_BTE_IN;
      WB_M_DAT_WR_OUT = WB_S1_DAT_WR_IN;
    end
  end

  logic [1:0]  s_stall;
  logic [1:0]  s_ack;
  logic [1:0]  s_err;
  logic [31:0] s_dat [2];

  // Requester-side responses; late slave responses during an abort are dropped
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign s_stall[gi] = gnt_vec[gi] ? WB_M_STALL_IN : 1'b1;
      assign s_ack[gi]   = gnt_vec[gi] & WB_M_ACK_IN;
      assign s_err[gi]   = gnt_vec[gi] ? WB_M_ERR_IN : (abort_vec[gi] & abort_first_q);
      assign s_dat[gi]   = gnt_vec[gi] ? WB_M_DAT_RD_IN : 32'd0;
    end
  endgenerate

  assign WB_S0_STALL_OUT  = s_stall[0];
  assign WB_S0_ACK_OUT    = s_ack[0];
  assign WB_S0_ERR_OUT    = s_err[0];
  assign WB_S0_DAT_RD_OUT = s_dat[0];
  assign WB_S1_STALL_OUT  = s_stall[1];
  assign WB_S1_ACK_OUT    = s_ack[1];
  assign WB_S1_ERR_OUT    = s_err[1];
  assign WB_S1_DAT_RD_OUT = s_dat[1];

  assign GNT_OUT     = gnt_vec;
  assign TIMEOUT_OUT = abort_first_q;

endmodule
